clock_decrease_nco: RTL and testbench

//  Parametrised digital successor to the fixed-ratio PLL clock-decrease wrapper.

---
 rtl/clock_decrease_nco.sv | 157 +++++++++++++++
 tb/tb_clock_decrease_nco.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_decrease_nco.sv
// Fractional-rate clock-enable generator: NUM_CLOCKS independent phase
// accumulators each emit a registered strobe at long-run rate mul/div of refclk.
// Channels are reconfigured at runtime through a valid/ready port; locked
// reports that every channel has been running its current config for
// LOCK_DELAY cycles.
// Ports:
//   refclk     clock, all logic on rising edge
//   rst        asynchronous reset, active-low
//   en         1 = accumulators advance, 0 = freeze (strobes forced low)
//   cfg_valid  config request
//   cfg_ready  config port can accept (registered)
//   cfg_chan   target channel
//   cfg_mul    new numerator
//   cfg_div    new denominator
//   cfg_err    one-cycle pulse on a rejected request (registered)
//   outce      per-channel clock-enable strobe (registered)
//   locked     all channels running a settled config (registered)
module clock_decrease_nco #(
  parameter int unsigned NUM_CLOCKS = 1,
  parameter int unsigned ACC_W      = 16,
  parameter int unsigned MUL_INIT   = 2,
  parameter int unsigned DIV_INIT   = 5,
  parameter int unsigned LOCK_DELAY = 16,
  localparam int unsigned CHAN_W    = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CHAN_W-1:0]     cfg_chan,
  input  logic [ACC_W-1:0]      cfg_mul,
  input  logic [ACC_W-1:0]      cfg_div,
  output logic                  cfg_err,
  output logic [NUM_CLOCKS-1:0] outce,
  output logic                  locked
);

  localparam int unsigned CNT_W = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOCK_DELAY - 1);

  localparam logic [0:0] SETTLE = 1'b0;
  localparam logic [0:0] IDLE   = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             locked_d, ready_d, err_d;
  logic             req, bad, load;

  logic [ACC_W-1:0]      acc_q [NUM_CLOCKS];
  logic [ACC_W-1:0]      acc_d [NUM_CLOCKS];
  logic [ACC_W-1:0]      mul_q [NUM_CLOCKS];
  logic [ACC_W-1:0]      mul_d [NUM_CLOCKS];
  logic [ACC_W-1:0]      div_q [NUM_CLOCKS];
  logic [ACC_W-1:0]      div_d [NUM_CLOCKS];
  logic [ACC_W:0]        sum   [NUM_CLOCKS];
  logic [NUM_CLOCKS-1:0] outce_d;

  // Request decode: a handshake only happens while the port is ready.
  always_comb begin
    req = cfg_valid && cfg_ready;
    bad = (cfg_div == '0) || (cfg_mul == '0) || (cfg_mul > cfg_div) ||
          (32'(cfg_chan) >= NUM_CLOCKS);
  end

  // Settle/accept FSM next-state logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    locked_d = locked;
    ready_d  = cfg_ready;
    err_d    = 1'b0;
    load     = 1'b0;
    case (state_q)
      SETTLE: begin
        ready_d = 1'b0;
        if (cnt_q == '0) begin
          state_d  = IDLE;
          locked_d = 1'b1;
          ready_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      IDLE: begin
        if (req) begin
          if (bad) begin
            err_d = 1'b1;
          end else begin
            load     = 1'b1;
            locked_d = 1'b0;
            ready_d  = 1'b0;
            cnt_d    = CNT_INIT;
            state_d  = SETTLE;
          end
        end
      end
      default: begin
        state_d = SETTLE;
        cnt_d   = CNT_INIT;
      end
    endcase
  end

  // Per-channel accumulators; sum carries one extra bit so mul+acc never wraps.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
      sum[i]     = {1'b0, acc_q[i]} + {1'b0, mul_q[i]};
      acc_d[i]   = acc_q[i];
      mul_d[i]   = mul_q[i];
      div_d[i]   = div_q[i];
      outce_d[i] = 1'b0;
      if (load && (cfg_chan == CHAN_W'(i))) begin
        mul_d[i] = cfg_mul;
        div_d[i] = cfg_div;
        acc_d[i] = '0;
      end else if (en) begin
        if (sum[i] >= {1'b0, div_q[i]}) begin
          acc_d[i]   = ACC_W'(sum[i] - {1'b0, div_q[i]});
          outce_d[i] = 1'b1;
        end else begin
          acc_d[i] = ACC_W'(sum[i]);
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state_q   <= SETTLE;
      cnt_q     <= CNT_INIT;
      locked    <= 1'b0;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
      outce     <= '0;
      for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
        acc_q[i] <= '0;
        mul_q[i] <= ACC_W'(MUL_INIT);
        div_q[i] <= ACC_W'(DIV_INIT);
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      locked    <= locked_d;
      cfg_ready <= ready_d;
      cfg_err   <= err_d;
      outce     <= outce_d;
      for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
        acc_q[i] <= acc_d[i];
        mul_q[i] <= mul_d[i];
        div_q[i] <= div_d[i];
      end
    end
  end

endmodule

// File: tb/tb_clock_decrease_nco.sv
// Bench for clock_decrease_nco with three channels. Expected strobes come
// from hand-derived periodic patterns (period + residue mask) per channel.
module tb_clock_decrease_nco;

  localparam int unsigned NCH = 3;

  logic        refclk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [1:0]  cfg_chan = '0;
  logic [15:0] cfg_mul = '0;
  logic [15:0] cfg_div = '0;
  logic        cfg_ready;
  logic        cfg_err;
  logic [2:0]  outce;
  logic        locked;

  int checks = 0;
  int errors = 0;

  // Expected-strobe tracker: after the j-th enabled edge since (re)load,
  // outce = msk[j % per]. Edge of load, or any edge with en=0, gives 0.
  int         per   [NCH];
  logic [7:0] msk   [NCH];
  int         jj    [NCH];
  logic       exp_o [NCH];

  typedef struct {
    logic [1:0]  chan;
    logic [15:0] mul;
    logic [15:0] div;
    logic        exp_err;
    logic        exp_locked;
  } rej_t;

  rej_t rej [4];

  clock_decrease_nco #(.NUM_CLOCKS(3)) dut (
    .refclk    (refclk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_mul   (cfg_mul),
    .cfg_div   (cfg_div),
    .cfg_err   (cfg_err),
    .outce     (outce),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, expv);
    end
  endtask

  task automatic set_pat(input int c, input int p, input logic [7:0] m);
    per[c]   = p;
    msk[c]   = m;
    jj[c]    = 0;
    exp_o[c] = 1'b0;
  endtask

  task automatic init_default();
    for (int c = 0; c < NCH; c++) set_pat(c, 5, 8'b0000_1001);
  endtask

  // One clock edge; ld names a channel loaded on this edge (-1 for none).
  task automatic tick(input int ld, input int p, input logic [7:0] m);
    @(posedge refclk);
    for (int c = 0; c < NCH; c++) begin
      if (c == ld) begin
        set_pat(c, p, m);
      end else if (!en) begin
        exp_o[c] = 1'b0;
      end else begin
        jj[c]++;
        exp_o[c] = msk[c][jj[c] % per[c]];
      end
    end
    #1;
    for (int c = 0; c < NCH; c++)
      chk($sformatf("outce%0d_j%0d", c, jj[c]), int'(outce[c]), int'(exp_o[c]));
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(-1, 0, 8'h00);
  endtask

  task automatic settle(input int k0);
    for (int k = k0; k <= 16; k++) begin
      tick(-1, 0, 8'h00);
      chk($sformatf("locked_k%0d", k), int'(locked), int'(k == 16));
      chk($sformatf("ready_k%0d", k), int'(cfg_ready), int'(k == 16));
    end
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [15:0] m, input logic [15:0] d,
                     input int p, input logic [7:0] pm);
    cfg_valid = 1'b1;
    cfg_chan  = ch;
    cfg_mul   = m;
    cfg_div   = d;
    tick(int'(ch), p, pm);
    cfg_valid = 1'b0;
    chk("accept_locked", int'(locked), 0);
    chk("accept_ready", int'(cfg_ready), 0);
    chk("accept_err", int'(cfg_err), 0);
  endtask

  task automatic count_strobes(input int n, input int c, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick(-1, 0, 8'h00);
      cnt += int'(outce[c]);
    end
  endtask

  initial begin
    int cnt;
    rej[0] = '{chan: 2'd0, mul: 16'd1, div: 16'd0, exp_err: 1'b1, exp_locked: 1'b1};
    rej[1] = '{chan: 2'd0, mul: 16'd6, div: 16'd5, exp_err: 1'b1, exp_locked: 1'b1};
    rej[2] = '{chan: 2'd0, mul: 16'd0, div: 16'd5, exp_err: 1'b1, exp_locked: 1'b1};
    rej[3] = '{chan: 2'd3, mul: 16'd2, div: 16'd5, exp_err: 1'b1, exp_locked: 1'b1};

    // Reset state
    rst = 1'b0;
    en  = 1'b1;
    repeat (3) @(posedge refclk);
    #1;
    chk("rst_outce", int'(outce), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_ready", int'(cfg_ready), 0);
    chk("rst_err", int'(cfg_err), 0);

    // Release, default 2/5 on every channel, 16-cycle lock
    init_default();
    rst = 1'b1;
    settle(1);
    count_strobes(100, 0, cnt);
    chk("rate_2_5", cnt, 40);

    // Reconfigure ch0 to 1/4; requests while not ready are ignored
    cfg(2'd0, 16'd1, 16'd4, 4, 8'b0000_0001);
    cfg_valid = 1'b1;
    cfg_chan  = 2'd2;
    cfg_mul   = 16'd1;
    cfg_div   = 16'd1;
    settle(1 - 0 + 0 > 0 ? 1 : 1) ;
    cfg_valid = 1'b0;
    count_strobes(100, 0, cnt);
    chk("rate_1_4", cnt, 25);

    // Rejected requests
    for (int r = 0; r < 4; r++) begin
      cfg_valid = 1'b1;
      cfg_chan  = rej[r].chan;
      cfg_mul   = rej[r].mul;
      cfg_div   = rej[r].div;
      tick(-1, 0, 8'h00);
      cfg_valid = 1'b0;
      chk($sformatf("rej%0d_err", r), int'(cfg_err), int'(rej[r].exp_err));
      chk($sformatf("rej%0d_locked", r), int'(locked), int'(rej[r].exp_locked));
      chk($sformatf("rej%0d_ready", r), int'(cfg_ready), 1);
      tick(-1, 0, 8'h00);
      chk($sformatf("rej%0d_err_clr", r), int'(cfg_err), 0);
      idle_ticks(6);
    end

    // mul == div: constant strobe
    cfg(2'd0, 16'd7, 16'd7, 1, 8'b0000_0001);
    settle(1);
    idle_ticks(10);

    // 3/8 with a 10-cycle freeze mid-run
    cfg(2'd0, 16'd3, 16'd8, 8, 8'b0100_1001);
    settle(1);
    idle_ticks(5);
    en = 1'b0;
    idle_ticks(10);
    chk("freeze_locked", int'(locked), 1);
    en = 1'b1;
    idle_ticks(20);

    // Full-scale ch1 while ch0/ch2 keep running
    cfg(2'd1, 16'hFFFF, 16'hFFFF, 1, 8'b0000_0001);
    settle(1);
    idle_ticks(20);

    // Async reset in the middle of a settle (cnt == 5)
    cfg(2'd2, 16'd1, 16'd4, 4, 8'b0000_0001);
    idle_ticks(10);
    chk("pre_rst_outce1", int'(outce[1]), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_outce", int'(outce), 0);
    chk("arst_locked", int'(locked), 0);
    chk("arst_ready", int'(cfg_ready), 0);
    chk("arst_err", int'(cfg_err), 0);
    @(posedge refclk);
    @(posedge refclk);
    #1;
    chk("arst_hold_outce", int'(outce), 0);
    init_default();
    rst = 1'b1;
    settle(1);
    idle_ticks(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
